// File: rtl/chip8_fetch_pkg.sv
// chip8_fetch_pkg
//   Shared definitions for the CHIP-8 instruction-fetch stage: FSM state
//   encodings (also used by the CPU control FSM and the bench) and the
//   default program entry point.
package chip8_fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 12;
  localparam logic [11:0] RESET_PC_DEF = 12'h200;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR_HI = 2'd1,
    ST_ADDR_LO = 2'd2,
    ST_CAPTURE = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/chip8_fetch.sv
// chip8_fetch
//   Instruction-fetch stage of the CHIP-8 CPU. Owns the program counter,
//   reads the two opcode bytes (big-endian) from a byte-wide program RAM with
//   a one-cycle registered read, and presents the assembled opcode with a
//   one-cycle valid strobe. Also applies PC loads and skips from control.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   fetch_req    in   start a fetch at the current PC (IDLE only)
//   pc_load      in   load PC from pc_load_val (IDLE only, highest priority)
//   pc_load_val  in   new PC value
//   pc_skip      in   PC += 2 (IDLE only, below pc_load)
//   mem_addr     out  program-RAM byte address
//   mem_rd       out  program-RAM read enable
//   mem_rdata    in   RAM read data, valid one cycle after addr+rd
//   opcode       out  last fetched instruction {hi, lo}
//   opcode_valid out  one-cycle strobe, opcode updated
//   pc           out  address of the next instruction to fetch
//   busy         out  high whenever the FSM is not IDLE
module chip8_fetch
  import chip8_fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              pc_skip,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       opcode,
  output logic              opcode_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_TWO = ADDR_W'(2);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       opcode_q, opcode_d;
  logic              opcode_valid_q, opcode_valid_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    mem_addr_d     = mem_addr_q;
    mem_rd_d       = mem_rd_q;
    hi_d           = hi_q;
    opcode_d       = opcode_q;
    opcode_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Only one request acts per edge; a fetch coinciding with a load or
        // skip is dropped and control reissues it.
        if (pc_load) begin
          pc_d = pc_load_val;
        end else if (pc_skip) begin
          pc_d = pc_q + PC_TWO;
        end else if (fetch_req) begin
          mem_addr_d = pc_q;
          mem_rd_d   = 1'b1;
          state_d    = ST_ADDR_HI;
        end
      end
      ST_ADDR_HI: begin
        mem_addr_d = pc_q + PC_ONE;
        state_d    = ST_ADDR_LO;
      end
      ST_ADDR_LO: begin
        // RAM now returns the byte at pc (address issued one edge ago).
        hi_d     = mem_rdata;
        mem_rd_d = 1'b0;
        state_d  = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        opcode_d       = {hi_q, mem_rdata};
        opcode_valid_d = 1'b1;
        pc_d           = pc_q + PC_TWO;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      pc_q           <= RESET_PC;
      mem_addr_q     <= '0;
      mem_rd_q       <= 1'b0;
      hi_q           <= 8'h00;
      opcode_q       <= 16'h0000;
      opcode_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      mem_addr_q     <= mem_addr_d;
      mem_rd_q       <= mem_rd_d;
      hi_q           <= hi_d;
      opcode_q       <= opcode_d;
      opcode_valid_q <= opcode_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_rd       = mem_rd_q;
  assign opcode       = opcode_q;
  assign opcode_valid = opcode_valid_q;
  assign pc           = pc_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_chip8_fetch.sv
module tb_chip8_fetch;
  import chip8_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_req;
  logic        pc_load;
  logic [11:0] pc_load_val;
  logic        pc_skip;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'h00;
  logic [15:0] opcode;
  logic        opcode_valid;
  logic [11:0] pc;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int viol_cnt = 0;

  logic [7:0] ram [0:4095];

  chip8_fetch #(.ADDR_W(12), .RESET_PC(12'h200)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .pc_skip(pc_skip), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_rdata(mem_rdata), .opcode(opcode),
    .opcode_valid(opcode_valid), .pc(pc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Program RAM: one-cycle registered read.
  always @(posedge clk) if (mem_rd) mem_rdata <= ram[mem_addr];

  // Protocol monitor: control must not issue requests while busy.
  always @(negedge clk)
    if (reset_n && busy && (fetch_req || pc_load || pc_skip)) begin
      viol_cnt++;
      $display("note: request while busy at %0t (ignored by fetch stage)", $time);
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  // Full fetch from IDLE starting at address a; checks the address sequence,
  // the opcode hold during the fetch and the final result.
  task automatic run_fetch(input logic [11:0] a, input logic [15:0] exp_op,
                           input logic [15:0] prev_op);
    logic [11:0] a1;
    logic [11:0] a2;
    a1 = a + 12'd1;
    a2 = a + 12'd2;
    fetch_req = 1'b1;
    step();                                   // E0
    fetch_req = 1'b0;
    check("e0_addr", 32'(mem_addr), 32'(a));
    check("e0_rd", 32'(mem_rd), 32'd1);
    check("e0_busy", 32'(busy), 32'd1);
    step();                                   // E1
    check("e1_addr", 32'(mem_addr), 32'(a1));
    check("e1_rd", 32'(mem_rd), 32'd1);
    step();                                   // E2
    check("e2_rd", 32'(mem_rd), 32'd0);
    check("mid_opcode_hold", 32'(opcode), 32'(prev_op));
    check("mid_valid", 32'(opcode_valid), 32'd0);
    step();                                   // E3
    check("e3_valid", 32'(opcode_valid), 32'd1);
    check("e3_opcode", 32'(opcode), 32'(exp_op));
    check("e3_pc", 32'(pc), 32'(a2));
    check("e3_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    int          kind;     // 0 load, 1 skip, 2 fetch
    logic [11:0] val;      // load value, or fetch start address
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [11:0] exp_pc;
    logic [15:0] exp_op;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [15:0] cur_op;
    logic [11:0] wa;
    int vcount;

    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    reset_n = 1'b0; fetch_req = 1'b0; pc_load = 1'b0; pc_load_val = '0; pc_skip = 1'b0;

    vecs[0] = '{2, 12'h200, 8'h12, 8'h34, 12'h202, 16'h1234};
    vecs[1] = '{2, 12'h202, 8'h00, 8'hE0, 12'h204, 16'h00E0};
    vecs[2] = '{0, 12'h3A0, 8'h00, 8'h00, 12'h3A0, 16'h00E0};
    vecs[3] = '{1, 12'h000, 8'h00, 8'h00, 12'h3A2, 16'h00E0};
    vecs[4] = '{2, 12'h3A2, 8'h6A, 8'h05, 12'h3A4, 16'h6A05};
    vecs[5] = '{0, 12'hFFF, 8'h00, 8'h00, 12'hFFF, 16'h6A05};
    vecs[6] = '{2, 12'hFFF, 8'hAB, 8'hCD, 12'h001, 16'hABCD};
    vecs[7] = '{0, 12'hFFE, 8'h00, 8'h00, 12'hFFE, 16'hABCD};
    vecs[8] = '{1, 12'h000, 8'h00, 8'h00, 12'h000, 16'hABCD};

    // Reset values
    repeat (2) step();
    check("rst_pc", 32'(pc), 32'h200);
    check("rst_opcode", 32'(opcode), 32'h0);
    check("rst_valid", 32'(opcode_valid), 32'd0);
    check("rst_rd", 32'(mem_rd), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    step();

    // Table-driven sequence
    cur_op = 16'h0000;
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].kind == 2) begin
        wa = vecs[i].val;
        ram[wa] = vecs[i].hi;
        wa = wa + 12'd1;
        ram[wa] = vecs[i].lo;
        run_fetch(vecs[i].val, vecs[i].exp_op, cur_op);
        step();
        check("post_valid_drop", 32'(opcode_valid), 32'd0);
      end else begin
        pc_load     = (vecs[i].kind == 0);
        pc_skip     = (vecs[i].kind == 1);
        pc_load_val = vecs[i].val;
        step();
        pc_load = 1'b0; pc_skip = 1'b0;
        check("ctl_pc", 32'(pc), 32'(vecs[i].exp_pc));
        check("ctl_busy", 32'(busy), 32'd0);
        check("ctl_opcode_hold", 32'(opcode), 32'(vecs[i].exp_op));
        check("ctl_valid", 32'(opcode_valid), 32'd0);
      end
      check("vec_pc", 32'(pc), 32'(vecs[i].exp_pc));
      cur_op = vecs[i].exp_op;
    end

    // Back-to-back fetches
    do_reset();
    ram[12'h200] = 8'h12; ram[12'h201] = 8'h34;
    ram[12'h202] = 8'h56; ram[12'h203] = 8'h78;
    run_fetch(12'h200, 16'h1234, 16'h0000);
    fetch_req = 1'b1;                         // valid cycle: new fetch accepted
    step();
    fetch_req = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_addr", 32'(mem_addr), 32'h202);
    check("b2b_valid_drop", 32'(opcode_valid), 32'd0);
    step();
    check("b2b_addr_lo", 32'(mem_addr), 32'h203);
    step();
    check("b2b_hold", 32'(opcode), 32'h1234);
    step();
    check("b2b_valid", 32'(opcode_valid), 32'd1);
    check("b2b_opcode", 32'(opcode), 32'h5678);
    check("b2b_pc", 32'(pc), 32'h204);

    // fetch_req coincident with pc_load: load wins, fetch dropped
    step();
    fetch_req = 1'b1; pc_load = 1'b1; pc_load_val = 12'h3A0;
    step();
    fetch_req = 1'b0; pc_load = 1'b0;
    check("coinc_pc", 32'(pc), 32'h3A0);
    check("coinc_busy", 32'(busy), 32'd0);
    check("coinc_rd", 32'(mem_rd), 32'd0);
    step();
    check("coinc_busy2", 32'(busy), 32'd0);

    // Reset mid-fetch (state ADDR_LO)
    fetch_req = 1'b1;
    step();                                   // E0 at 3A0
    fetch_req = 1'b0;
    step();                                   // E1 -> ADDR_LO
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_pc", 32'(pc), 32'h200);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rd", 32'(mem_rd), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'h0);
    check("mid_rst_opcode", 32'(opcode), 32'h0);
    check("mid_rst_valid", 32'(opcode_valid), 32'd0);
    step();
    reset_n = 1'b1;
    vcount = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (opcode_valid) vcount++;
    end
    check("mid_rst_no_valid", 32'(vcount), 32'd0);
    check("mid_rst_pc_after", 32'(pc), 32'h200);

    // Requests while busy are ignored
    ram[12'h200] = 8'hA1; ram[12'h201] = 8'h23;
    viol_cnt = 0;
    vcount = 0;
    fetch_req = 1'b1;
    step();                                   // E0
    fetch_req = 1'b0;
    pc_skip = 1'b1;                           // seen at E1 while busy
    step();
    pc_skip = 1'b0;
    check("ign_addr", 32'(mem_addr), 32'h201);
    fetch_req = 1'b1;                         // seen at E2 while busy
    step();
    fetch_req = 1'b0;
    step();                                   // E3
    if (opcode_valid) vcount++;
    check("ign_opcode", 32'(opcode), 32'hA123);
    check("ign_pc", 32'(pc), 32'h202);
    for (int c = 0; c < 6; c++) begin
      step();
      if (opcode_valid) vcount++;
    end
    check("ign_single_valid", 32'(vcount), 32'd1);
    check("ign_pc_final", 32'(pc), 32'h202);
    check("ign_busy_final", 32'(busy), 32'd0);
    check("ign_violations_seen", 32'(viol_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
